// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction-fetch stage. Owns the fetch PC and issues one
//               word request at a time to instruction memory over a
//               req/ready + rvalid handshake. Returned words are queued with
//               their PCs in a small in-order FIFO and presented to decode
//               over valid/ready. Execute can redirect the PC at any time,
//               which flushes the queue and discards any in-flight response.
//               Once the core raises finish, fetching stops for good; the
//               queue keeps draining.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WORD       datapath / address width in bits
//   RESET_PC   first fetch address after reset (word aligned)
//   DEPTH      instruction queue entries (power of two, >= 2)
// Ports
//   clk            core clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   o_imem_req     fetch request valid
//   o_imem_addr    byte address of the requested word
//   i_imem_ready   memory accepts the request this cycle
//   i_imem_rvalid  response valid
//   i_imem_rdata   fetched instruction
//   i_redirect     one-cycle pulse: flush and refetch from i_redirect_pc
//   i_redirect_pc  redirect target (low two bits ignored)
//   i_finish       stop fetching; held high once set
//   o_out_valid    o_out_instr / o_out_pc hold a valid instruction
//   i_out_ready    decode consumes the head entry
//   o_out_instr    head instruction
//   o_out_pc       PC of the head instruction
// ============================================================================
module ifetch_unit #(
   parameter int              WORD     = 32,
   parameter logic [WORD-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   // instruction memory
   output logic            o_imem_req,
   output logic [WORD-1:0] o_imem_addr,
   input  logic            i_imem_ready,
   input  logic            i_imem_rvalid,
   input  logic [WORD-1:0] i_imem_rdata,
   // control from execute / core
   input  logic            i_redirect,
   input  logic [WORD-1:0] i_redirect_pc,
   input  logic            i_finish,
   // decode side
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [WORD-1:0] o_out_instr,
   output logic [WORD-1:0] o_out_pc
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so the count can represent a completely full queue.
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);
   localparam logic [WORD-1:0]  c_PC_STEP = WORD'(4);
   localparam logic [WORD-1:0]  c_ALIGN   = ~WORD'(3);

   // -------------------------------------------------------------------------
   // Fetch FSM state
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t            r_state;
   logic [WORD-1:0]   r_pc;        // next address to request
   logic [WORD-1:0]   r_fetch_pc;  // address of the in-flight request
   logic              r_drop;      // in-flight response belongs to a dead path

   // -------------------------------------------------------------------------
   // Instruction queue
   // -------------------------------------------------------------------------
   logic [WORD-1:0]   r_q_instr [DEPTH];
   logic [WORD-1:0]   r_q_pc    [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;

   // -------------------------------------------------------------------------
   // Combinational control
   // -------------------------------------------------------------------------
   logic              w_outstanding;
   logic [CNT_W-1:0]  w_inflight;
   logic              w_room;
   logic              w_req;
   logic              w_accept;
   logic              w_rsp;
   logic              w_redir;
   logic              w_push;
   logic              w_pop;
   logic [WORD-1:0]   w_redir_pc;

   // A request is only outstanding while the FSM sits in WAIT.
   assign w_outstanding = (r_state == S_WAIT);

   // Gate requests on queued entries plus the in-flight one so a returning
   // response always finds a free slot. Uses the registered count only, so a
   // pop in the current cycle frees a slot for the following cycle.
   assign w_inflight = r_count + CNT_W'(w_outstanding);
   assign w_room     = (w_inflight < c_DEPTH);

   // finish suppresses any new request immediately, even one already shown.
   assign w_req    = (r_state == S_REQ) & w_room & ~i_finish;
   assign w_accept = w_req & i_imem_ready;
   assign w_rsp    = w_outstanding & i_imem_rvalid;

   // finish takes priority over redirect, and a halted unit ignores redirects.
   assign w_redir    = i_redirect & ~i_finish & (r_state != S_HALT);
   assign w_redir_pc = i_redirect_pc & c_ALIGN;

   // A redirect flushes the queue, so neither a response nor a pop in the
   // same cycle may touch it.
   assign w_push = w_rsp & ~r_drop & ~w_redir;
   assign w_pop  = o_out_valid & i_out_ready & ~w_redir;

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign o_imem_req  = w_req;
   assign o_imem_addr = r_pc;
   assign o_out_valid = (r_count != '0);
   assign o_out_instr = r_q_instr[r_rptr];
   assign o_out_pc    = r_q_pc[r_rptr];

   // -------------------------------------------------------------------------
   // Fetch FSM, PC and drop flag
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_fetch_pc <= '0;
         r_drop     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_REQ;
               if (w_redir) begin
                  r_pc <= w_redir_pc;
               end
            end

            S_REQ: begin
               if (i_finish) begin
                  r_state <= S_HALT;
               end else if (w_accept) begin
                  r_state    <= S_WAIT;
                  r_fetch_pc <= r_pc;
                  // Accepted in the redirect cycle: the response is stale.
                  r_drop     <= w_redir;
                  r_pc       <= w_redir ? w_redir_pc : (r_pc + c_PC_STEP);
               end else if (w_redir) begin
                  // Unaccepted request is withdrawn; next cycle shows new PC.
                  r_pc <= w_redir_pc;
               end
            end

            S_WAIT: begin
               if (w_redir) begin
                  r_pc <= w_redir_pc;
               end
               if (w_rsp) begin
                  // Response completes the transaction whether kept or not.
                  r_drop  <= 1'b0;
                  r_state <= i_finish ? S_HALT : S_REQ;
               end else if (w_redir) begin
                  // Still waiting on a request from the old path.
                  r_drop <= 1'b1;
               end
            end

            S_HALT: begin
               r_state <= S_HALT;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Instruction queue
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_instr[i] <= '0;
            r_q_pc[i]    <= '0;
         end
      end else if (w_redir) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_q_instr[r_wptr] <= i_imem_rdata;
            r_q_pc[r_wptr]    <= r_fetch_pc;
            r_wptr            <= r_wptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed self-checking bench for ifetch_unit. A behavioural
//               instruction memory with programmable latency answers every
//               accepted request with a word derived from its address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

   logic        clk;
   logic        rst_n;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ready;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        i_finish;
   logic        o_out_valid;
   logic        i_out_ready;
   logic [31:0] o_out_instr;
   logic [31:0] o_out_pc;

   int          tests_run;
   int          tests_failed;

   // memory model state
   int          mem_lat;
   logic        pend;
   int          pend_cnt;
   logic [31:0] pend_addr;
   int          n_acc;
   logic [31:0] last_acc;
   logic [31:0] acc_log [0:15];

   ifetch_unit #(
      .WORD     (32),
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ready  (i_imem_ready),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .i_finish      (i_finish),
      .o_out_valid   (o_out_valid),
      .i_out_ready   (i_out_ready),
      .o_out_instr   (o_out_instr),
      .o_out_pc      (o_out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5EED_0013;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: inputs already set at the preceding negedge; returns at the
   // next negedge with the memory response for this edge applied.
   task automatic cycle();
      logic        acc;
      logic [31:0] a;
      #1;
      acc = o_imem_req & i_imem_ready;
      a   = o_imem_addr;
      @(posedge clk);
      #1;
      i_imem_rvalid = 1'b0;
      if (acc) begin
         pend      = 1'b1;
         pend_cnt  = mem_lat;
         pend_addr = a;
         if (n_acc < 16) acc_log[n_acc] = a;
         n_acc++;
         last_acc  = a;
      end
      if (pend) begin
         if (pend_cnt <= 1) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = instr_of(pend_addr);
            pend          = 1'b0;
         end else begin
            pend_cnt--;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      pend          = 1'b0;
      i_imem_rvalid = 1'b0;
      n_acc         = 0;
      last_acc      = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Advance at least one cycle, stop once out_valid is seen or bound expires.
   task automatic wait_valid(input string tag);
      int k;
      k = 0;
      do begin
         cycle();
         k++;
      end while (!o_out_valid && k < 16);
      check(tag, 32'(o_out_valid), 32'd1);
   endtask

   initial begin
      logic [31:0] exp_pc;
      int          k;
      int          n_save;
      logic        saw_valid;

      tests_run     = 0;
      tests_failed  = 0;
      rst_n         = 1'b0;
      i_imem_ready  = 1'b1;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
      i_redirect    = 1'b0;
      i_redirect_pc = '0;
      i_finish      = 1'b0;
      i_out_ready   = 1'b1;
      mem_lat       = 1;
      pend          = 1'b0;
      pend_cnt      = 0;
      pend_addr     = '0;
      n_acc         = 0;
      last_acc      = 32'hFFFF_FFFF;

      // ---------------- reset values and streaming from RESET_PC ----------
      repeat (2) @(negedge clk);
      check("rst_req",   32'(o_imem_req),  32'd0);
      check("rst_addr",  o_imem_addr,      32'h0);
      check("rst_valid", 32'(o_out_valid), 32'd0);
      check("rst_instr", o_out_instr,      32'h0);
      check("rst_pc",    o_out_pc,         32'h0);
      rst_n = 1'b1;
      cycle();                                   // edge 1: IDLE -> REQ
      check("first_req",  32'(o_imem_req), 32'd1);
      check("first_addr", o_imem_addr,     32'h0);
      cycle();                                   // edge 2: accept 0
      check("valid_e2", 32'(o_out_valid), 32'd0);
      cycle();                                   // edge 3: push 0
      check("valid_e3", 32'(o_out_valid), 32'd1);
      check("pc_e3",    o_out_pc,         32'h0);
      check("instr_e3", o_out_instr,      instr_of(32'h0));
      exp_pc = 32'h4;
      k = 0;
      while (exp_pc != 32'h10 && k < 20) begin
         cycle();
         k++;
         if (o_out_valid) begin
            check("stream_pc",    o_out_pc,    exp_pc);
            check("stream_instr", o_out_instr, instr_of(exp_pc));
            exp_pc = exp_pc + 32'h4;
         end
      end
      check("stream_done", exp_pc, 32'h10);
      check("fetch0", acc_log[0], 32'h0);
      check("fetch1", acc_log[1], 32'h4);
      check("fetch2", acc_log[2], 32'h8);
      check("fetch3", acc_log[3], 32'hC);

      // ---------------- backpressure ----------------
      i_out_ready = 1'b0;
      do_reset();
      repeat (10) cycle();
      check("bp_req",   32'(o_imem_req),  32'd0);
      check("bp_addr",  o_imem_addr,      32'h8);
      check("bp_valid", 32'(o_out_valid), 32'd1);
      check("bp_head",  o_out_pc,         32'h0);
      check("bp_nacc",  32'(n_acc),       32'd2);
      i_out_ready = 1'b1;
      cycle();
      check("bp_head2",  o_out_pc,         32'h4);
      check("bp_valid2", 32'(o_out_valid), 32'd1);
      check("bp_req2",   32'(o_imem_req),  32'd1);
      check("bp_addr2",  o_imem_addr,      32'h8);
      wait_valid("bp_resume_to");
      check("bp_resume_pc", o_out_pc, 32'h8);

      // ---------------- redirect with 0x10 outstanding ----------------
      do_reset();
      k = 0;
      while (!(n_acc == 4 && last_acc == 32'hC) && k < 20) begin
         cycle();
         k++;
      end
      check("rd_setup", last_acc, 32'hC);
      i_out_ready = 1'b0;
      mem_lat     = 3;
      cycle();                                   // push 0xC
      cycle();                                   // accept 0x10
      check("rd_acc10",  last_acc,          32'h10);
      check("rd_qvalid", 32'(o_out_valid),  32'd1);
      check("rd_qhead",  o_out_pc,          32'hC);
      i_redirect_pc = 32'h0000_0103;
      i_redirect    = 1'b1;
      cycle();
      i_redirect    = 1'b0;
      mem_lat       = 1;
      i_out_ready   = 1'b1;
      check("rd_flush",  32'(o_out_valid), 32'd0);
      check("rd_noreq",  32'(o_imem_req),  32'd0);
      saw_valid = 1'b0;
      k = 0;
      do begin
         cycle();
         k++;
         if (o_out_valid) saw_valid = 1'b1;
      end while (!o_imem_req && k < 16);
      check("rd_newaddr", o_imem_addr,    32'h100);
      check("rd_dropped", 32'(saw_valid), 32'd0);
      wait_valid("rd_valid_to");
      check("rd_outpc",    o_out_pc,    32'h100);
      check("rd_outinstr", o_out_instr, instr_of(32'h100));

      // ---------------- memory stall ----------------
      i_imem_ready = 1'b0;
      n_save = n_acc;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("stall_req",  32'(o_imem_req), 32'd1);
         check("stall_addr", o_imem_addr,     32'h104);
      end
      check("stall_nacc", 32'(n_acc), 32'(n_save));
      i_imem_ready = 1'b1;
      wait_valid("stall_valid_to");
      check("stall_outpc", o_out_pc, 32'h104);

      // ---------------- wrap ----------------
      i_redirect_pc = 32'hFFFF_FFFC;
      i_redirect    = 1'b1;
      cycle();
      i_redirect    = 1'b0;
      check("wrap_flush", 32'(o_out_valid), 32'd0);
      wait_valid("wrap_v1_to");
      check("wrap_pc1",    o_out_pc,    32'hFFFF_FFFC);
      check("wrap_instr1", o_out_instr, instr_of(32'hFFFF_FFFC));
      wait_valid("wrap_v2_to");
      check("wrap_pc2",    o_out_pc,    32'h0);
      check("wrap_instr2", o_out_instr, instr_of(32'h0));

      // ---------------- finish ----------------
      mem_lat = 2;
      cycle();                                   // accept 4
      check("fin_acc", last_acc, 32'h4);
      i_finish = 1'b1;
      cycle();
      check("fin_wait_req", 32'(o_imem_req), 32'd0);
      cycle();                                   // response for 4 pushed
      check("fin_valid", 32'(o_out_valid), 32'd1);
      check("fin_pc",    o_out_pc,         32'h4);
      check("fin_instr", o_out_instr,      instr_of(32'h4));
      i_out_ready = 1'b0;
      n_save = n_acc;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("fin_noreq", 32'(o_imem_req), 32'd0);
      end
      i_redirect_pc = 32'h0000_0200;
      i_redirect    = 1'b1;
      cycle();
      i_redirect    = 1'b0;
      check("halt_addr",  o_imem_addr,      32'h8);
      check("halt_valid", 32'(o_out_valid), 32'd1);
      check("halt_head",  o_out_pc,         32'h4);
      check("halt_nacc",  32'(n_acc),       32'(n_save));

      // ---------------- asynchronous reset mid-cycle ----------------
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_req",   32'(o_imem_req),  32'd0);
      check("arst_addr",  o_imem_addr,      32'h0);
      check("arst_valid", 32'(o_out_valid), 32'd0);
      check("arst_instr", o_out_instr,      32'h0);
      check("arst_pc",    o_out_pc,         32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
